dispatch_stage: RTL and testbench

// Registered dispatch stage between decode and N reservation stations (RS): resolves both source operands
// (regfile -> ROB -> pending tag), holds one instruction in an output register, snoops the CDB while held,
// and hands it to the one-hot selected RS over a valid/ready handshake. Replaces purely combinational

---
 rtl/dispatch_stage.sv | 195 +++++++++++++++++++
 tb/tb_dispatch_stage.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dispatch_stage.sv
// dispatch_stage: one-entry registered dispatch buffer that resolves operands, snoops the CDB and hands off to a one-hot RS; DISP_STALL_CNT_EN enables the stall counter
module dispatch_stage #(
    parameter int NUM_RS     = 3,
    parameter int XLEN       = 32,
    parameter int ROB_IDX_W  = 5,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [NUM_RS-1:0]     rs_sel_i,
    input  logic [6:0]            op_i,
    input  logic [6:0]            funct7_i,
    input  logic [2:0]            funct3_i,
    input  logic [XLEN-1:0]       imm_i,
    input  logic [XLEN-1:0]       pc_i,
    input  logic [ROB_IDX_W-1:0]  rob_id_i,
    input  logic [REG_ADDR_W-1:0] rs1_addr_i,
    input  logic [REG_ADDR_W-1:0] rs2_addr_i,
    output logic [REG_ADDR_W-1:0] rf_addr1_o,
    output logic [REG_ADDR_W-1:0] rf_addr2_o,
    input  logic                  rf_rdy1_i,
    input  logic                  rf_rdy2_i,
    input  logic [XLEN-1:0]       rf_data1_i,
    input  logic [XLEN-1:0]       rf_data2_i,
    input  logic [ROB_IDX_W-1:0]  rf_tag1_i,
    input  logic [ROB_IDX_W-1:0]  rf_tag2_i,
    output logic [ROB_IDX_W-1:0]  rob_tag1_o,
    output logic [ROB_IDX_W-1:0]  rob_tag2_o,
    input  logic                  rob_rdy1_i,
    input  logic                  rob_rdy2_i,
    input  logic [XLEN-1:0]       rob_data1_i,
    input  logic [XLEN-1:0]       rob_data2_i,
    input  logic                  cdb_valid_i,
    input  logic [ROB_IDX_W-1:0]  cdb_tag_i,
    input  logic [XLEN-1:0]       cdb_data_i,
    output logic [NUM_RS-1:0]     rs_valid_o,
    input  logic [NUM_RS-1:0]     rs_ready_i,
    output logic [XLEN-1:0]       out_a_o,
    output logic [XLEN-1:0]       out_b_o,
    output logic                  out_a_rdy_o,
    output logic                  out_b_rdy_o,
    output logic [ROB_IDX_W-1:0]  out_a_tag_o,
    output logic [ROB_IDX_W-1:0]  out_b_tag_o,
    output logic [6:0]            out_op_o,
    output logic [6:0]            out_funct7_o,
    output logic [2:0]            out_funct3_o,
    output logic [XLEN-1:0]       out_imm_o,
    output logic [XLEN-1:0]       out_pc_o,
    output logic [ROB_IDX_W-1:0]  out_rob_id_o,
    output logic [15:0]           stall_cnt_o
);
    typedef enum logic {EMPTY, HELD} state_t;

    state_t                 r_state, w_state_nxt;
    logic [NUM_RS-1:0]      r_sel;
    logic [6:0]             r_op, r_funct7;
    logic [2:0]             r_funct3;
    logic [XLEN-1:0]        r_imm, r_pc;
    logic [ROB_IDX_W-1:0]   r_rob_id;
    logic [XLEN-1:0]        r_a, r_b;
    logic                   r_a_rdy, r_b_rdy;
    logic [ROB_IDX_W-1:0]   r_a_tag, r_b_tag;

    logic                   w_held, w_fire, w_accept;
    logic                   w_a_cdb, w_b_cdb, w_a_rdy_n, w_b_rdy_n;
    logic [XLEN-1:0]        w_a_data_n, w_b_data_n;
    logic [ROB_IDX_W-1:0]   w_a_tag_n, w_b_tag_n;
    logic                   w_a_wake, w_b_wake;

    assign w_held     = r_state == HELD;
    assign rs_valid_o = w_held ? r_sel : '0;
    assign w_fire     = |(rs_valid_o & rs_ready_i);
    assign in_ready_o = !w_held | w_fire;
    assign w_accept   = in_valid_i & in_ready_o & !flush_i & (|rs_sel_i);

    assign rf_addr1_o = rs1_addr_i;
    assign rf_addr2_o = rs2_addr_i;
    assign rob_tag1_o = rf_tag1_i;
    assign rob_tag2_o = rf_tag2_i;

    // Resolve incoming operands: CDB broadcast, then regfile, then ROB, else wait on the tag
    always_comb begin
        w_a_cdb    = cdb_valid_i && cdb_tag_i == rf_tag1_i && cdb_tag_i != '0;
        w_b_cdb    = cdb_valid_i && cdb_tag_i == rf_tag2_i && cdb_tag_i != '0;
        w_a_rdy_n  = w_a_cdb | rf_rdy1_i | rob_rdy1_i;
        w_b_rdy_n  = w_b_cdb | rf_rdy2_i | rob_rdy2_i;
        w_a_data_n = w_a_cdb ? cdb_data_i : rf_rdy1_i ? rf_data1_i : rob_rdy1_i ? rob_data1_i : '0;
        w_b_data_n = w_b_cdb ? cdb_data_i : rf_rdy2_i ? rf_data2_i : rob_rdy2_i ? rob_data2_i : '0;
        w_a_tag_n  = w_a_rdy_n ? '0 : rf_tag1_i;
        w_b_tag_n  = w_b_rdy_n ? '0 : rf_tag2_i;
    end

    // Held operands still waiting on a tag wake up when the CDB broadcasts that tag
    always_comb begin
        w_a_wake     = w_held && !r_a_rdy && cdb_valid_i && cdb_tag_i == r_a_tag && r_a_tag != '0;
        w_b_wake     = w_held && !r_b_rdy && cdb_valid_i && cdb_tag_i == r_b_tag && r_b_tag != '0;
        out_a_o      = w_a_wake ? cdb_data_i : r_a;
        out_b_o      = w_b_wake ? cdb_data_i : r_b;
        out_a_rdy_o  = r_a_rdy | w_a_wake;
        out_b_rdy_o  = r_b_rdy | w_b_wake;
        out_a_tag_o  = w_a_wake ? '0 : r_a_tag;
        out_b_tag_o  = w_b_wake ? '0 : r_b_tag;
    end

    assign out_op_o     = r_op;
    assign out_funct7_o = r_funct7;
    assign out_funct3_o = r_funct3;
    assign out_imm_o    = r_imm;
    assign out_pc_o     = r_pc;
    assign out_rob_id_o = r_rob_id;

    // Next state: flush empties, accept (incl. back-to-back with fire) holds, lone fire empties
    always_comb begin
        w_state_nxt = flush_i ? EMPTY : w_accept ? HELD : w_fire ? EMPTY : r_state;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= EMPTY;
        else      r_state <= w_state_nxt;
    end

    // Payload register, loaded only on accept so it stays stable while waiting for the RS
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sel    <= '0;
            r_op     <= '0;
            r_funct7 <= '0;
            r_funct3 <= '0;
            r_imm    <= '0;
            r_pc     <= '0;
            r_rob_id <= '0;
        end else if (w_accept) begin
            r_sel    <= rs_sel_i;
            r_op     <= op_i;
            r_funct7 <= funct7_i;
            r_funct3 <= funct3_i;
            r_imm    <= imm_i;
            r_pc     <= pc_i;
            r_rob_id <= rob_id_i;
        end
    end

    // Operand A: resolved value on accept, CDB capture while held
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a     <= '0;
            r_a_rdy <= 1'b0;
            r_a_tag <= '0;
        end else if (w_accept) begin
            r_a     <= w_a_data_n;
            r_a_rdy <= w_a_rdy_n;
            r_a_tag <= w_a_tag_n;
        end else if (w_a_wake) begin
            r_a     <= cdb_data_i;
            r_a_rdy <= 1'b1;
            r_a_tag <= '0;
        end
    end

    // Operand B: resolved value on accept, CDB capture while held
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_b     <= '0;
            r_b_rdy <= 1'b0;
            r_b_tag <= '0;
        end else if (w_accept) begin
            r_b     <= w_b_data_n;
            r_b_rdy <= w_b_rdy_n;
            r_b_tag <= w_b_tag_n;
        end else if (w_b_wake) begin
            r_b     <= cdb_data_i;
            r_b_rdy <= 1'b1;
            r_b_tag <= '0;
        end
    end

`ifdef DISP_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Count cycles an instruction is held but not taken, saturating at all-ones
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                                     r_stall_cnt <= '0;
        else if (w_held && !w_fire && !flush_i && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
    end

    assign stall_cnt_o = r_stall_cnt;
`else
    assign stall_cnt_o = 16'h0000;
`endif

endmodule

// File: tb/tb_dispatch_stage.sv
// tb_dispatch_stage: directed and randomized checks of dispatch_stage against an instruction-level model
module tb_dispatch_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i, in_valid_i, in_ready_o;
    logic [2:0]  rs_sel_i, rs_valid_o, rs_ready_i;
    logic [6:0]  op_i, funct7_i, out_op_o, out_funct7_o;
    logic [2:0]  funct3_i, out_funct3_o;
    logic [31:0] imm_i, pc_i, out_imm_o, out_pc_o;
    logic [4:0]  rob_id_i, out_rob_id_o, rs1_addr_i, rs2_addr_i, rf_addr1_o, rf_addr2_o;
    logic        rf_rdy1_i, rf_rdy2_i, rob_rdy1_i, rob_rdy2_i;
    logic [31:0] rf_data1_i, rf_data2_i, rob_data1_i, rob_data2_i;
    logic [4:0]  rf_tag1_i, rf_tag2_i, rob_tag1_o, rob_tag2_o;
    logic        cdb_valid_i;
    logic [4:0]  cdb_tag_i;
    logic [31:0] cdb_data_i;
    logic [31:0] out_a_o, out_b_o;
    logic        out_a_rdy_o, out_b_rdy_o;
    logic [4:0]  out_a_tag_o, out_b_tag_o;
    logic [15:0] stall_cnt_o;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic        rdy;
        logic [31:0] d;
        logic [4:0]  t;
    } opnd_t;

    typedef struct packed {
        logic        v;
        logic [2:0]  sel;
        logic [6:0]  op;
        logic [31:0] pc;
        logic [4:0]  rob;
        opnd_t       a;
        opnd_t       b;
    } instr_t;

    instr_t m;
    int     m_stall;

    dispatch_stage dut (
        .clk(clk), .rst(rst), .flush_i(flush_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .rs_sel_i(rs_sel_i), .op_i(op_i), .funct7_i(funct7_i), .funct3_i(funct3_i), .imm_i(imm_i),
        .pc_i(pc_i), .rob_id_i(rob_id_i), .rs1_addr_i(rs1_addr_i), .rs2_addr_i(rs2_addr_i),
        .rf_addr1_o(rf_addr1_o), .rf_addr2_o(rf_addr2_o), .rf_rdy1_i(rf_rdy1_i), .rf_rdy2_i(rf_rdy2_i),
        .rf_data1_i(rf_data1_i), .rf_data2_i(rf_data2_i), .rf_tag1_i(rf_tag1_i), .rf_tag2_i(rf_tag2_i),
        .rob_tag1_o(rob_tag1_o), .rob_tag2_o(rob_tag2_o), .rob_rdy1_i(rob_rdy1_i), .rob_rdy2_i(rob_rdy2_i),
        .rob_data1_i(rob_data1_i), .rob_data2_i(rob_data2_i), .cdb_valid_i(cdb_valid_i),
        .cdb_tag_i(cdb_tag_i), .cdb_data_i(cdb_data_i), .rs_valid_o(rs_valid_o), .rs_ready_i(rs_ready_i),
        .out_a_o(out_a_o), .out_b_o(out_b_o), .out_a_rdy_o(out_a_rdy_o), .out_b_rdy_o(out_b_rdy_o),
        .out_a_tag_o(out_a_tag_o), .out_b_tag_o(out_b_tag_o), .out_op_o(out_op_o),
        .out_funct7_o(out_funct7_o), .out_funct3_o(out_funct3_o), .out_imm_o(out_imm_o),
        .out_pc_o(out_pc_o), .out_rob_id_o(out_rob_id_o), .stall_cnt_o(stall_cnt_o)
    );

    always #5 clk = ~clk;

    // An operand as seen by the RS this cycle: a waiting tag broadcast now counts as ready
    function automatic opnd_t view(input opnd_t o);
        if (!o.rdy && cdb_valid_i && cdb_tag_i == o.t && o.t != 0) return '{1'b1, cdb_data_i, 5'd0};
        return o;
    endfunction

    // Where a new source operand's value comes from, in order of freshness
    function automatic opnd_t resolve(input logic rr, input logic [31:0] rd, input logic [4:0] t,
                                      input logic br, input logic [31:0] bd);
        if (cdb_valid_i && cdb_tag_i == t && t != 0) return '{1'b1, cdb_data_i, 5'd0};
        if (rr) return '{1'b1, rd, 5'd0};
        if (br) return '{1'b1, bd, 5'd0};
        return '{1'b0, 32'd0, t};
    endfunction

    function automatic int exp_stall();
`ifdef DISP_STALL_CNT_EN
        return m_stall;
`else
        return 0;
`endif
    endfunction

    // Advance the model by one clock using the inputs currently applied, then take the edge
    task automatic model_step();
        logic fire, acc;
        fire = m.v && |(m.sel & rs_ready_i);
        acc  = in_valid_i && (!m.v || fire) && !flush_i && |rs_sel_i;
        if (m.v && !fire && !flush_i && m_stall != 16'hFFFF) m_stall++;
        if (flush_i) m.v = 1'b0;
        else if (acc) begin
            m.v = 1'b1; m.sel = rs_sel_i; m.op = op_i; m.pc = pc_i; m.rob = rob_id_i;
            m.a = resolve(rf_rdy1_i, rf_data1_i, rf_tag1_i, rob_rdy1_i, rob_data1_i);
            m.b = resolve(rf_rdy2_i, rf_data2_i, rf_tag2_i, rob_rdy2_i, rob_data2_i);
        end else if (fire) m.v = 1'b0;
        else if (m.v) begin
            m.a = view(m.a);
            m.b = view(m.b);
        end
        @(posedge clk);
    endtask

    task automatic idle();
        flush_i = 0; in_valid_i = 0; rs_sel_i = 0; op_i = 0; funct7_i = 0; funct3_i = 0;
        imm_i = 0; pc_i = 0; rob_id_i = 0; rs1_addr_i = 0; rs2_addr_i = 0;
        rf_rdy1_i = 0; rf_rdy2_i = 0; rf_data1_i = 0; rf_data2_i = 0; rf_tag1_i = 0; rf_tag2_i = 0;
        rob_rdy1_i = 0; rob_rdy2_i = 0; rob_data1_i = 0; rob_data2_i = 0;
        cdb_valid_i = 0; cdb_tag_i = 0; cdb_data_i = 0; rs_ready_i = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst = 0;
        m = '0;
        m_stall = 0;
        @(negedge clk);
        rst = 1;
    endtask

    task automatic test_reset();
        rst = 0;
        idle();
        m = '0;
        m_stall = 0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (rs_valid_o !== 3'b000) begin failures++; $display("FAIL reset_valid got=%b exp=000", rs_valid_o); end
        checks++; if (out_a_o !== 0 || out_a_rdy_o !== 0 || out_pc_o !== 0) begin failures++; $display("FAIL reset_payload a=%h rdy=%b pc=%h exp=0", out_a_o, out_a_rdy_o, out_pc_o); end
        checks++; if (stall_cnt_o !== 16'h0) begin failures++; $display("FAIL reset_stall got=%h exp=0", stall_cnt_o); end
        rst = 1;
        #1;
        checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready_o); end
        @(negedge clk);
        in_valid_i = 1; rs_sel_i = 3'b100; rf_rdy1_i = 1; rf_rdy2_i = 1;
        #1;
        model_step();
        @(negedge clk);
        idle();
        #1;
        checks++; if (rs_valid_o !== 3'b100) begin failures++; $display("FAIL reset_pre_held got=%b exp=100", rs_valid_o); end
        rst = 0;
        #1;
        checks++; if (rs_valid_o !== 3'b000) begin failures++; $display("FAIL reset_mid_held got=%b exp=000", rs_valid_o); end
        m = '0;
        m_stall = 0;
        @(negedge clk);
        rst = 1;
        #1;
        checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL reset_release_ready got=%b exp=1", in_ready_o); end
    endtask

    task automatic test_resolve();
        do_reset();
        @(negedge clk);
        in_valid_i = 1; rs_sel_i = 3'b010; rf_rdy1_i = 1; rf_data1_i = 32'h11;
        rf_rdy2_i = 0; rf_tag2_i = 5'd7; rob_rdy2_i = 1; rob_data2_i = 32'h22; pc_i = 32'h1000;
        #1;
        model_step();
        @(negedge clk);
        idle();
        #1;
        checks++; if (rs_valid_o !== 3'b010) begin failures++; $display("FAIL resolve_valid got=%b exp=010", rs_valid_o); end
        checks++; if (out_a_o !== 32'h11 || out_a_rdy_o !== 1 || out_a_tag_o !== 0) begin failures++; $display("FAIL resolve_a got=%h/%b/%0d exp=11/1/0", out_a_o, out_a_rdy_o, out_a_tag_o); end
        checks++; if (out_b_o !== 32'h22 || out_b_rdy_o !== 1 || out_b_tag_o !== 0) begin failures++; $display("FAIL resolve_b got=%h/%b/%0d exp=22/1/0", out_b_o, out_b_rdy_o, out_b_tag_o); end
        checks++; if (in_ready_o !== 1'b0) begin failures++; $display("FAIL resolve_backpressure got=%b exp=0", in_ready_o); end
        rs_ready_i = 3'b101;
        #1;
        checks++; if (in_ready_o !== 1'b0) begin failures++; $display("FAIL resolve_unselected_ready got=%b exp=0", in_ready_o); end
        rs_ready_i = 3'b010;
        #1;
        model_step();
        @(negedge clk);
        idle();
        #1;
        checks++; if (rs_valid_o !== 3'b000) begin failures++; $display("FAIL resolve_drained got=%b exp=000", rs_valid_o); end
    endtask

    task automatic test_cdb_wakeup();
        do_reset();
        @(negedge clk);
        in_valid_i = 1; rs_sel_i = 3'b001; rf_rdy1_i = 1; rf_data1_i = 32'h1; rf_tag2_i = 5'd9;
        #1;
        model_step();
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            idle();
            if (c == 2) begin cdb_valid_i = 1; cdb_tag_i = 5'd9; cdb_data_i = 32'hDEAD; end
            if (c == 4) rs_ready_i = 3'b001;
            #1;
            if (c == 1) begin
                checks++; if (out_b_rdy_o !== 0 || out_b_tag_o !== 5'd9) begin failures++; $display("FAIL wake_pending got=%b/%0d exp=0/9", out_b_rdy_o, out_b_tag_o); end
            end else begin
                checks++; if (out_b_rdy_o !== 1 || out_b_o !== 32'hDEAD || out_b_tag_o !== 0) begin failures++; $display("FAIL wake_c%0d got=%b/%h/%0d exp=1/dead/0", c, out_b_rdy_o, out_b_o, out_b_tag_o); end
            end
            if (c == 4) begin
                checks++; if (stall_cnt_o !== 16'(exp_stall())) begin failures++; $display("FAIL wake_stall got=%0d exp=%0d", stall_cnt_o, exp_stall()); end
            end
            model_step();
        end
    endtask

    task automatic test_bypass_fire();
        do_reset();
        @(negedge clk);
        in_valid_i = 1; rs_sel_i = 3'b100; rf_rdy1_i = 1; rf_data1_i = 32'h3; rf_tag2_i = 5'd4;
        #1;
        model_step();
        @(negedge clk);
        idle();
        cdb_valid_i = 1; cdb_tag_i = 5'd4; cdb_data_i = 32'h5; rs_ready_i = 3'b100;
        #1;
        checks++; if (rs_valid_o !== 3'b100) begin failures++; $display("FAIL bypass_valid got=%b exp=100", rs_valid_o); end
        checks++; if (out_b_o !== 32'h5 || out_b_rdy_o !== 1 || out_b_tag_o !== 0) begin failures++; $display("FAIL bypass_b got=%h/%b/%0d exp=5/1/0", out_b_o, out_b_rdy_o, out_b_tag_o); end
        model_step();
        @(negedge clk);
        idle();
        #1;
        checks++; if (rs_valid_o !== 3'b000 || in_ready_o !== 1) begin failures++; $display("FAIL bypass_after got=%b/%b exp=000/1", rs_valid_o, in_ready_o); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            idle();
            in_valid_i = (i < 4); rs_sel_i = 3'(1 << (i % 3)); pc_i = 32'(100 + i);
            rf_rdy1_i = 1; rf_rdy2_i = 1; rs_ready_i = 3'b111;
            #1;
            checks++; if (in_ready_o !== 1'b1) begin failures++; $display("FAIL b2b_ready_%0d got=%b exp=1", i, in_ready_o); end
            if (i > 0) begin
                checks++; if (rs_valid_o !== 3'(1 << ((i - 1) % 3)) || out_pc_o !== 32'(99 + i)) begin failures++; $display("FAIL b2b_out_%0d got=%b/%0d exp=%b/%0d", i, rs_valid_o, out_pc_o, 3'(1 << ((i - 1) % 3)), 99 + i); end
            end else begin
                checks++; if (rs_valid_o !== 3'b000) begin failures++; $display("FAIL b2b_out_0 got=%b exp=000", rs_valid_o); end
            end
            model_step();
        end
    endtask

    task automatic test_flush();
        do_reset();
        @(negedge clk);
        in_valid_i = 1; rs_sel_i = 3'b001; pc_i = 32'h40; rf_rdy1_i = 1; rf_rdy2_i = 1;
        #1;
        model_step();
        @(negedge clk);
        flush_i = 1; rs_ready_i = 3'b111; in_valid_i = 1; rs_sel_i = 3'b010; pc_i = 32'h80;
        #1;
        checks++; if (in_ready_o !== 1'b1 || rs_valid_o !== 3'b001) begin failures++; $display("FAIL flush_cycle got=%b/%b exp=1/001", in_ready_o, rs_valid_o); end
        model_step();
        @(negedge clk);
        idle();
        #1;
        checks++; if (rs_valid_o !== 3'b000) begin failures++; $display("FAIL flush_dropped got=%b exp=000", rs_valid_o); end
        model_step();
    endtask

    task automatic test_random();
        int n;
        logic [2:0] sels [4] = '{3'b000, 3'b001, 3'b010, 3'b100};
        opnd_t ea, eb;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            flush_i = ($urandom_range(19) == 0);
            in_valid_i = $urandom_range(3) != 0;
            n = ($urandom_range(7) == 0) ? 0 : $urandom_range(1, 3);
            rs_sel_i = sels[n];
            op_i = 7'($urandom); funct7_i = 7'($urandom); funct3_i = 3'($urandom);
            imm_i = $urandom; pc_i = $urandom; rob_id_i = 5'($urandom);
            rs1_addr_i = 5'($urandom); rs2_addr_i = 5'($urandom);
            rf_rdy1_i = $urandom_range(2) == 0; rf_rdy2_i = $urandom_range(2) == 0;
            rf_data1_i = $urandom; rf_data2_i = $urandom;
            rf_tag1_i = 5'($urandom_range(1, 7)); rf_tag2_i = 5'($urandom_range(1, 7));
            rob_rdy1_i = $urandom_range(2) == 0; rob_rdy2_i = $urandom_range(2) == 0;
            rob_data1_i = $urandom; rob_data2_i = $urandom;
            cdb_valid_i = $urandom_range(1); cdb_tag_i = 5'($urandom_range(0, 7)); cdb_data_i = $urandom;
            rs_ready_i = 3'($urandom);
            #1;
            ea = view(m.a);
            eb = view(m.b);
            checks++; if (rs_valid_o !== (m.v ? m.sel : 3'b000)) begin failures++; $display("FAIL rnd_valid @%0d got=%b exp=%b", i, rs_valid_o, m.v ? m.sel : 3'b000); end
            checks++; if (in_ready_o !== (!m.v || |(m.sel & rs_ready_i))) begin failures++; $display("FAIL rnd_in_ready @%0d got=%b", i, in_ready_o); end
            checks++; if (rf_addr1_o !== rs1_addr_i || rob_tag2_o !== rf_tag2_i) begin failures++; $display("FAIL rnd_lookup @%0d got=%0d/%0d exp=%0d/%0d", i, rf_addr1_o, rob_tag2_o, rs1_addr_i, rf_tag2_i); end
            checks++; if (stall_cnt_o !== 16'(exp_stall())) begin failures++; $display("FAIL rnd_stall @%0d got=%0d exp=%0d", i, stall_cnt_o, exp_stall()); end
            if (m.v) begin
                checks++; if ({out_a_rdy_o, out_a_o, out_a_tag_o} !== ea) begin failures++; $display("FAIL rnd_a @%0d got=%b/%h/%0d exp=%b/%h/%0d", i, out_a_rdy_o, out_a_o, out_a_tag_o, ea.rdy, ea.d, ea.t); end
                checks++; if ({out_b_rdy_o, out_b_o, out_b_tag_o} !== eb) begin failures++; $display("FAIL rnd_b @%0d got=%b/%h/%0d exp=%b/%h/%0d", i, out_b_rdy_o, out_b_o, out_b_tag_o, eb.rdy, eb.d, eb.t); end
                checks++; if (out_op_o !== m.op || out_pc_o !== m.pc || out_rob_id_o !== m.rob) begin failures++; $display("FAIL rnd_payload @%0d got=%h/%h/%0d exp=%h/%h/%0d", i, out_op_o, out_pc_o, out_rob_id_o, m.op, m.pc, m.rob); end
            end
            model_step();
        end
    endtask

    initial begin
        test_reset();
        test_resolve();
        test_cdb_wakeup();
        test_bypass_fire();
        test_back_to_back();
        test_flush();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
